seg_scan_ctrl: RTL and testbench

Parametrised N-digit multiplexed seven-segment display controller. It replaces the fixed two-digit refresh/decode/divider chain in the CPU top level. It holds a display data register written by the CPU (write-enable gated by the CPU clock enable), derives its own scan rate from the system clock, and inserts a ghost-suppression blanking interval at every digit change. Outputs drive board anodes and segments directly (active-low).

---
 rtl/seg_scan_ctrl_if.sv | 23 ++
 rtl/seg_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: CPU-side write port and board-side display pins of the
// multiplexed seven-segment controller. The CPU (master) drives the data and
// strobes; the controller (slave) drives the active-low anodes and segments.
interface seg_scan_ctrl_if #(
    parameter int NDIG = 4
);
    logic                Cen;
    logic                We;
    logic [4*NDIG-1:0]   Din;
    logic [NDIG-1:0]     DpIn;
    logic [NDIG-1:0]     Anodes;
    logic [7:0]          Seg;

    modport master (
        output Cen, We, Din, DpIn,
        input  Anodes, Seg
    );

    modport slave (
        input  Cen, We, Din, DpIn,
        output Anodes, Seg
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: N-digit multiplexed seven-segment display controller.
// Free-running prescaler defines one digit slot of P = CLK_HZ/SCAN_HZ cycles;
// the first BLANK_CYC cycles of every slot keep all anodes off to suppress
// ghosting. Anodes and segments are registered and active-low.
// Optional feature: define SEG_LZ_BLANK_EN for leading-zero suppression.
//
//   state | meaning
//   BLANK | cnt < BLANK_CYC, all anodes off, segments dark
//   SHOW  | cnt >= BLANK_CYC, digit dig lit with its decoded nibble
module seg_scan_ctrl #(
    parameter int NDIG      = 4,
    parameter int CLK_HZ    = 100_000_000,
    parameter int SCAN_HZ   = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic            Clk,
    input  logic            Rst,
    seg_scan_ctrl_if.slave  bus
);
    localparam int P  = CLK_HZ / SCAN_HZ;
    localparam int CW = $clog2(P);
    localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DW-1:0]       dig_q, dig_d;
    logic [4*NDIG-1:0]   data_q;
    logic [NDIG-1:0]     dp_q;
    logic [NDIG-1:0]     anodes_q, anodes_d;
    logic [7:0]          seg_q, seg_d;
    logic [3:0]          nib;
    logic                cnt_wrap;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign cnt_wrap = (cnt_q == CW'(P - 1));

    // Prescaler and digit index advance
    always_comb begin
        cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
        dig_d = dig_q;
        if (cnt_wrap) begin
            dig_d = (dig_q == DW'(NDIG - 1)) ? '0 : dig_q + 1'b1;
        end
    end

    // CPU write port: loads only when the CPU clock enable qualifies We
    always_ff @(posedge Clk) begin
        if (Rst) begin
            data_q <= '0;
            dp_q   <= '0;
        end else if (bus.We && bus.Cen) begin
            data_q <= bus.Din;
            dp_q   <= bus.DpIn;
        end
    end

    // State, scan counters and output register share one edge
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= BLANK;
            cnt_q    <= '0;
            dig_q    <= '0;
            anodes_q <= '1;
            seg_q    <= 8'hFF;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dig_q    <= dig_d;
            anodes_q <= anodes_d;
            seg_q    <= seg_d;
        end
    end

    // Next state follows the slot position
    always_comb begin
        state_d = state_q;
        case (state_q)
            BLANK:   if (cnt_q == CW'(BLANK_CYC - 1)) state_d = SHOW;
            SHOW:    if (cnt_wrap) state_d = BLANK;
            default: state_d = BLANK;
        endcase
    end

`ifdef SEG_LZ_BLANK_EN
    logic lz_blank;

    // Digit k > 0 is suppressed when it and every higher nibble are zero
    always_comb begin
        lz_blank = (dig_q != '0) && ((data_q >> {dig_q, 2'b00}) == '0);
    end
`endif

    // Pin values for the next edge, decoded from the current scan state
    always_comb begin
        anodes_d = '1;
        seg_d    = 8'hFF;
        nib      = data_q[{dig_q, 2'b00} +: 4];
        if (state_q == SHOW) begin
            anodes_d[dig_q] = 1'b0;
            seg_d           = {~dp_q[dig_q], hex7(nib)};
`ifdef SEG_LZ_BLANK_EN
            if (lz_blank) begin
                seg_d[6:0] = 7'b1111111;
            end
`endif
        end
    end

    assign bus.Anodes = anodes_q;
    assign bus.Seg    = seg_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: bench for seg_scan_ctrl with P=10, BLANK_CYC=2, NDIG=4.
// A slot-arithmetic model predicts the pins every cycle; directed sections pin
// the model with hand-computed values; a random section exercises the rest.
module tb_seg_scan_ctrl;
    localparam int NDIG      = 4;
    localparam int CLK_HZ    = 1000;
    localparam int SCAN_HZ   = 100;
    localparam int BLANK_CYC = 2;
    localparam int P         = CLK_HZ / SCAN_HZ;

    localparam logic [6:0] DEC [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

`ifdef SEG_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    seg_scan_ctrl_if #(.NDIG(NDIG)) bus ();

    seg_scan_ctrl #(
        .NDIG(NDIG), .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLANK_CYC(BLANK_CYC)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Behavioural model: slot position from elapsed cycles since reset
    logic [15:0] m_data;
    logic [3:0]  m_dp;
    int          m_t;
    bit          m_valid = 1'b0;

    always @(posedge Clk) begin : model
        logic [3:0] ea;
        logic [7:0] es;
        int c, d;
        ea = '1;
        es = 8'hFF;
        cyc++;
        if (Rst) begin
            m_t = 0; m_data = '0; m_dp = '0; m_valid = 1'b1;
        end else begin
            c = m_t % P;
            d = (m_t / P) % NDIG;
            if (c >= BLANK_CYC) begin
                ea[d] = 1'b0;
                es    = {~m_dp[d], DEC[m_data[d*4 +: 4]]};
                if (LZ && d > 0 && (m_data >> (4*d)) == 16'h0) es[6:0] = 7'b1111111;
            end
            m_t++;
            if (bus.We && bus.Cen) begin
                m_data = bus.Din;
                m_dp   = bus.DpIn;
            end
        end
        #1;
        if (m_valid) begin
            chk("model_anodes", 32'(bus.Anodes), 32'(ea));
            chk("model_seg", 32'(bus.Seg), 32'(es));
        end
    end

    task automatic write(input logic [15:0] din, input logic [3:0] dp);
        @(negedge Clk);
        bus.Din = din; bus.DpIn = dp; bus.We = 1'b1; bus.Cen = 1'b1;
        @(negedge Clk);
        bus.We = 1'b0; bus.Cen = 1'b0;
    endtask

    // Wait for the first lit cycle of the digit whose anode pattern is val
    task automatic wait_start(input logic [3:0] val, output int st, output int len,
                              output logic [7:0] sg);
        int n;
        n = 0; len = 0;
        while (bus.Anodes == val && n < 200) begin @(posedge Clk); #1; n++; end
        while (bus.Anodes != val && n < 200) begin @(posedge Clk); #1; n++; end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL timeout_anodes actual=%0h required=%0h", bus.Anodes, val);
        end
        st = cyc;
        sg = bus.Seg;
        while (bus.Anodes == val && len < 200) begin len++; @(posedge Clk); #1; end
    endtask

    initial begin : stim
        int st[5], ln[5], n, m;
        logic [7:0] sg[5];
        bus.Cen = 1'b0; bus.We = 1'b0; bus.Din = '0; bus.DpIn = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk); Rst = 1'b0;
        repeat (17) @(negedge Clk);

        // Reset mid-slot with the scan running
        Rst = 1'b1;
        @(posedge Clk); #1;
        chk("reset_anodes", 32'(bus.Anodes), 32'h0000000F);
        chk("reset_seg", 32'(bus.Seg), 32'h000000FF);
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        n = 0;
        do begin @(posedge Clk); #1; n++; end while (bus.Anodes != 4'b1110 && n < 50);
        chk("first_lit_edge", 32'(n), 32'd3);
        m = 1;
        forever begin
            @(posedge Clk); #1;
            if (bus.Anodes == 4'b1110 && m < 50) m++; else break;
        end
        chk("first_lit_len", 32'(m), 32'd8);

        // Scan of 1234
        write(16'h1234, 4'b0000);
        wait_start(4'b0111, st[0], ln[0], sg[0]);
        wait_start(4'b1110, st[0], ln[0], sg[0]);
        wait_start(4'b1101, st[1], ln[1], sg[1]);
        wait_start(4'b1011, st[2], ln[2], sg[2]);
        wait_start(4'b0111, st[3], ln[3], sg[3]);
        wait_start(4'b1110, st[4], ln[4], sg[4]);
        chk("scan_d0", 32'(sg[0]), 32'h99);
        chk("scan_d1", 32'(sg[1]), 32'hB0);
        chk("scan_d2", 32'(sg[2]), 32'hA4);
        chk("scan_d3", 32'(sg[3]), 32'hF9);
        chk("scan_lit_len", 32'(ln[0]), 32'd8);
        chk("scan_dark_gap", 32'(st[1] - (st[0] + ln[0])), 32'd2);
        chk("scan_slot", 32'(st[2] - st[1]), 32'd10);
        chk("scan_period", 32'(st[4] - st[0]), 32'd40);

        // Cen gating
        @(negedge Clk);
        bus.Din = 16'hFFFF; bus.We = 1'b1; bus.Cen = 1'b0;
        wait_start(4'b1101, st[0], ln[0], sg[0]);
        chk("cen_gated", 32'(sg[0]), 32'hB0);
        @(negedge Clk); bus.Cen = 1'b1;
        @(negedge Clk); bus.Cen = 1'b0; bus.We = 1'b0;
        wait_start(4'b1011, st[0], ln[0], sg[0]);
        wait_start(4'b1110, st[1], ln[1], sg[1]);
        chk("cen_write_d2", 32'(sg[0]), 32'h8E);
        chk("cen_write_d0", 32'(sg[1]), 32'h8E);

        // Decimal point on digit 2 only
        write(16'h1234, 4'b0100);
        repeat (3) @(negedge Clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            chk("dp_follow", 32'(bus.Seg[7]), 32'(bus.Anodes != 4'b1011));
        end
        wait_start(4'b1011, st[0], ln[0], sg[0]);
        chk("dp_digit2", 32'(sg[0]), 32'h24);

        // Leading zeros
        write(16'h0050, 4'b0000);
        wait_start(4'b0111, st[0], ln[0], sg[0]);
        wait_start(4'b1110, st[0], ln[0], sg[0]);
        wait_start(4'b1101, st[1], ln[1], sg[1]);
        wait_start(4'b1011, st[2], ln[2], sg[2]);
        wait_start(4'b0111, st[3], ln[3], sg[3]);
        chk("lz_d0", 32'(sg[0]), 32'hC0);
        chk("lz_d1", 32'(sg[1]), 32'h92);
        chk("lz_d2", 32'(sg[2]), LZ ? 32'hFF : 32'hC0);
        chk("lz_d3", 32'(sg[3]), LZ ? 32'hFF : 32'hC0);
        write(16'h0000, 4'b0000);
        wait_start(4'b1110, st[0], ln[0], sg[0]);
        wait_start(4'b1101, st[1], ln[1], sg[1]);
        chk("zero_d0", 32'(sg[0]), 32'hC0);
        chk("zero_d1", 32'(sg[1]), LZ ? 32'hFF : 32'hC0);

        // Mid-slot write at cnt=5 of digit 0
        write(16'h1234, 4'b0000);
        wait_start(4'b0111, st[0], ln[0], sg[0]);
        wait_start(4'b1110, st[0], ln[0], sg[0]);
        // wait_start consumed the whole slot; wait for the next digit-0 start
        wait_start(4'b1110, st[0], ln[0], sg[0]);
        repeat (2) @(negedge Clk);
        // realign to the start of digit 0 with a dedicated start search
        n = 0;
        while (bus.Anodes != 4'b0111 && n < 100) begin @(posedge Clk); #1; n++; end
        while (bus.Anodes != 4'b1110 && n < 100) begin @(posedge Clk); #1; n++; end
        chk("mid_align", 32'(bus.Anodes), 32'hE);
        repeat (2) @(negedge Clk);
        @(negedge Clk);
        bus.Din = 16'hABCD; bus.We = 1'b1; bus.Cen = 1'b1;
        @(negedge Clk);
        bus.We = 1'b0; bus.Cen = 1'b0;
        chk("mid_old_seg", 32'(bus.Seg), 32'h99);
        @(posedge Clk); #1;
        chk("mid_new_seg", 32'(bus.Seg), 32'hA1);
        chk("mid_anodes", 32'(bus.Anodes), 32'hE);

        // Random traffic, occasional resets; the model checks every cycle
        for (int i = 0; i < 800; i++) begin
            @(negedge Clk);
            bus.Cen  = 1'($urandom_range(0, 1));
            bus.We   = ($urandom_range(0, 7) == 0);
            bus.Din  = 16'($urandom);
            bus.DpIn = 4'($urandom);
            Rst      = ($urandom_range(0, 149) == 0);
        end
        @(negedge Clk);
        Rst = 1'b0; bus.We = 1'b0; bus.Cen = 1'b0;
        repeat (5) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
